// File: rtl/pcie_rq_arbiter.sv
// pcie_rq_arbiter
//   Shares the PCIe requester-request (RQ) AXIS port between N_REQ upstream
//   requesters. Arbitration is round-robin at packet granularity: a grant is
//   held from the first beat until the requester's tlast beat is accepted.
//   The requester index is stamped into descriptor bits [103:102] (upper tag
//   bits) of the first beat of each packet. Requester-completion (RC) beats
//   are steered back to the owning requester using tdata[71:70].
//
// Optional feature macro: RQ_STAT_EN
//   defined   -> 16-bit per-requester accepted-packet counters on rq_pkt_cnt
//   undefined -> rq_pkt_cnt tied to zero, no counter flops
//
// Ports
//   user_clk, user_reset    clock, synchronous active-high reset
//   user_lnk_up             link up; low behaves as reset
//   req_t*                  packed requester RQ streams (slice i = requester i)
//   s_axis_rq_t*            registered RQ stream to the PCIe core
//   m_axis_rc_t*            RC stream from the PCIe core
//   rc_t*                   RC stream broadcast to requesters, per-requester valid/ready
//   rq_pkt_cnt              per-requester accepted-packet counters
//   arb_busy                high while a packet is locked
module pcie_rq_arbiter #(
  parameter int N_REQ               = 3,
  parameter int C_DATA_WIDTH        = 128,
  parameter int KEEP_WIDTH          = C_DATA_WIDTH / 32,
  parameter int AXI4_RQ_TUSER_WIDTH = 62,
  parameter int AXI4_RC_TUSER_WIDTH = 75
) (
  input  logic                                 user_clk,
  input  logic                                 user_reset,
  input  logic                                 user_lnk_up,
  input  logic [N_REQ*C_DATA_WIDTH-1:0]        req_tdata,
  input  logic [N_REQ*AXI4_RQ_TUSER_WIDTH-1:0] req_tuser,
  input  logic [N_REQ*KEEP_WIDTH-1:0]          req_tkeep,
  input  logic [N_REQ-1:0]                     req_tlast,
  input  logic [N_REQ-1:0]                     req_tvalid,
  output logic [N_REQ-1:0]                     req_tready,
  output logic [C_DATA_WIDTH-1:0]              s_axis_rq_tdata,
  output logic [AXI4_RQ_TUSER_WIDTH-1:0]       s_axis_rq_tuser,
  output logic [KEEP_WIDTH-1:0]                s_axis_rq_tkeep,
  output logic                                 s_axis_rq_tlast,
  output logic                                 s_axis_rq_tvalid,
  input  logic [3:0]                           s_axis_rq_tready,
  input  logic [C_DATA_WIDTH-1:0]              m_axis_rc_tdata,
  input  logic [AXI4_RC_TUSER_WIDTH-1:0]       m_axis_rc_tuser,
  input  logic [KEEP_WIDTH-1:0]                m_axis_rc_tkeep,
  input  logic                                 m_axis_rc_tlast,
  input  logic                                 m_axis_rc_tvalid,
  output logic                                 m_axis_rc_tready,
  output logic [C_DATA_WIDTH-1:0]              rc_tdata,
  output logic [AXI4_RC_TUSER_WIDTH-1:0]       rc_tuser,
  output logic [KEEP_WIDTH-1:0]                rc_tkeep,
  output logic                                 rc_tlast,
  output logic [N_REQ-1:0]                     rc_tvalid,
  input  logic [N_REQ-1:0]                     rc_tready,
  output logic [N_REQ*16-1:0]                  rq_pkt_cnt,
  output logic                                 arb_busy
);

  typedef enum logic {ARB = 1'b0, XFER = 1'b1} state_t;

  // Link loss discards everything exactly like an explicit reset.
  logic rst;
  assign rst = user_reset | ~user_lnk_up;

  // ---------------------------------------------------------------------
  // Arbitration FSM
  // ---------------------------------------------------------------------
  state_t     state_q, state_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [1:0] grant_q, grant_d;
  logic       first_beat_q, first_beat_d;

  logic                           out_ready;
  logic                           can_load;
  logic                           accept;
  logic                           pkt_done;
  logic [C_DATA_WIDTH-1:0]        sel_tdata;
  logic [AXI4_RQ_TUSER_WIDTH-1:0] sel_tuser;
  logic [KEEP_WIDTH-1:0]          sel_tkeep;
  logic                           sel_tlast;
  logic                           sel_tvalid;
  logic [C_DATA_WIDTH-1:0]        stamped_tdata;

  // Output register slice
  logic [C_DATA_WIDTH-1:0]        tdata_q;
  logic [AXI4_RQ_TUSER_WIDTH-1:0] tuser_q;
  logic [KEEP_WIDTH-1:0]          tkeep_q;
  logic                           tlast_q;
  logic                           tvalid_q;

  assign out_ready = |s_axis_rq_tready;
  // The slice can take a new beat when empty or when its beat leaves now.
  assign can_load  = !tvalid_q || out_ready;
  assign accept    = (state_q == XFER) && sel_tvalid && can_load;
  assign pkt_done  = accept && sel_tlast;

  // Select the granted requester's stream.
  always_comb begin
    sel_tdata  = '0;
    sel_tuser  = '0;
    sel_tkeep  = '0;
    sel_tlast  = 1'b0;
    sel_tvalid = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_q == 2'(i)) begin
        sel_tdata  = req_tdata[i*C_DATA_WIDTH +: C_DATA_WIDTH];
        sel_tuser  = req_tuser[i*AXI4_RQ_TUSER_WIDTH +: AXI4_RQ_TUSER_WIDTH];
        sel_tkeep  = req_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
        sel_tlast  = req_tlast[i];
        sel_tvalid = req_tvalid[i];
      end
    end
  end

  // Upper two tag bits carry the requester index on the descriptor beat only.
  always_comb begin
    stamped_tdata = sel_tdata;
    if (first_beat_q) begin
      stamped_tdata[103:102] = grant_q;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_ready
      assign req_tready[gi] = (state_q == XFER) && (grant_q == 2'(gi)) && can_load;
    end
  endgenerate

  always_comb begin
    int  idx;
    logic found;
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    grant_d      = grant_q;
    first_beat_d = first_beat_q;
    idx          = 0;
    found        = 1'b0;
    case (state_q)
      ARB: begin
        // First requesting index at or above rr_ptr, wrapping modulo N_REQ.
        for (int k = 0; k < N_REQ; k++) begin
          idx = (int'(rr_ptr_q) + k) % N_REQ;
          if (!found && req_tvalid[idx]) begin
            found   = 1'b1;
            grant_d = 2'(idx);
          end
        end
        if (found) begin
          state_d      = XFER;
          first_beat_d = 1'b1;
        end
      end
      XFER: begin
        if (accept) begin
          first_beat_d = 1'b0;
          if (sel_tlast) begin
            rr_ptr_d = (grant_q == 2'(N_REQ - 1)) ? 2'd0 : grant_q + 2'd1;
            state_d  = ARB;
          end
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge user_clk) begin
    if (rst) begin
      state_q      <= ARB;
      rr_ptr_q     <= 2'd0;
      grant_q      <= 2'd0;
      first_beat_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      grant_q      <= grant_d;
      first_beat_q <= first_beat_d;
    end
  end

  always_ff @(posedge user_clk) begin
    if (rst) begin
      tdata_q  <= '0;
      tuser_q  <= '0;
      tkeep_q  <= '0;
      tlast_q  <= 1'b0;
      tvalid_q <= 1'b0;
    end else if (accept) begin
      tdata_q  <= stamped_tdata;
      tuser_q  <= sel_tuser;
      tkeep_q  <= sel_tkeep;
      tlast_q  <= sel_tlast;
      tvalid_q <= 1'b1;
    end else if (out_ready) begin
      tvalid_q <= 1'b0;
    end
  end

  assign s_axis_rq_tdata  = tdata_q;
  assign s_axis_rq_tuser  = tuser_q;
  assign s_axis_rq_tkeep  = tkeep_q;
  assign s_axis_rq_tlast  = tlast_q;
  assign s_axis_rq_tvalid = tvalid_q;
  assign arb_busy         = (state_q == XFER);

  // ---------------------------------------------------------------------
  // Packet counters
  // ---------------------------------------------------------------------
`ifdef RQ_STAT_EN
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_cnt
      logic [15:0] cnt_q;
      always_ff @(posedge user_clk) begin
        if (rst) begin
          cnt_q <= 16'd0;
        end else if (pkt_done && (grant_q == 2'(gi))) begin
          cnt_q <= cnt_q + 16'd1;
        end
      end
      assign rq_pkt_cnt[gi*16 +: 16] = cnt_q;
    end
  endgenerate
`else
  assign rq_pkt_cnt = '0;
`endif

  // ---------------------------------------------------------------------
  // RC steering
  // ---------------------------------------------------------------------
  // The target is taken from the header beat; later beats of a multi-beat
  // completion carry payload in those bits, so the target is held until tlast.
  logic       rc_busy_q;
  logic [1:0] rc_tgt_q;
  logic [1:0] rc_tgt;
  logic       rc_hs;

  assign rc_tgt = rc_busy_q ? rc_tgt_q : m_axis_rc_tdata[71:70];
  assign rc_hs  = m_axis_rc_tvalid && m_axis_rc_tready;

  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_rc
      assign rc_tvalid[gi] = m_axis_rc_tvalid && (rc_tgt == 2'(gi));
    end
  endgenerate

  // Targets beyond N_REQ match nobody, so ready stays high and the beat drops.
  always_comb begin
    m_axis_rc_tready = 1'b1;
    for (int i = 0; i < N_REQ; i++) begin
      if (rc_tgt == 2'(i)) begin
        m_axis_rc_tready = rc_tready[i];
      end
    end
  end

  always_ff @(posedge user_clk) begin
    if (rst) begin
      rc_busy_q <= 1'b0;
      rc_tgt_q  <= 2'd0;
    end else if (!rc_busy_q) begin
      if (m_axis_rc_tvalid && !m_axis_rc_tlast) begin
        rc_busy_q <= 1'b1;
        rc_tgt_q  <= m_axis_rc_tdata[71:70];
      end
    end else if (rc_hs && m_axis_rc_tlast) begin
      rc_busy_q <= 1'b0;
    end
  end

  assign rc_tdata = m_axis_rc_tdata;
  assign rc_tuser = m_axis_rc_tuser;
  assign rc_tkeep = m_axis_rc_tkeep;
  assign rc_tlast = m_axis_rc_tlast;

endmodule

// File: tb/tb_pcie_rq_arbiter.sv
module tb_pcie_rq_arbiter;

    localparam int N   = 3;
    localparam int DW  = 128;
    localparam int KW  = DW / 32;
    localparam int RQU = 62;
    localparam int RCU = 75;
`ifdef RQ_STAT_EN
    localparam int STAT = 1;
`else
    localparam int STAT = 0;
`endif

    logic              user_clk = 1'b0;
    logic              user_reset;
    logic              user_lnk_up;
    logic [N*DW-1:0]   req_tdata;
    logic [N*RQU-1:0]  req_tuser;
    logic [N*KW-1:0]   req_tkeep;
    logic [N-1:0]      req_tlast;
    logic [N-1:0]      req_tvalid;
    logic [N-1:0]      req_tready;
    logic [DW-1:0]     s_axis_rq_tdata;
    logic [RQU-1:0]    s_axis_rq_tuser;
    logic [KW-1:0]     s_axis_rq_tkeep;
    logic              s_axis_rq_tlast;
    logic              s_axis_rq_tvalid;
    logic [3:0]        s_axis_rq_tready;
    logic [DW-1:0]     m_axis_rc_tdata;
    logic [RCU-1:0]    m_axis_rc_tuser;
    logic [KW-1:0]     m_axis_rc_tkeep;
    logic              m_axis_rc_tlast;
    logic              m_axis_rc_tvalid;
    logic              m_axis_rc_tready;
    logic [DW-1:0]     rc_tdata;
    logic [RCU-1:0]    rc_tuser;
    logic [KW-1:0]     rc_tkeep;
    logic              rc_tlast;
    logic [N-1:0]      rc_tvalid;
    logic [N-1:0]      rc_tready;
    logic [N*16-1:0]   rq_pkt_cnt;
    logic              arb_busy;

    int total = 0;
    int bad   = 0;

    pcie_rq_arbiter #(
        .N_REQ(N), .C_DATA_WIDTH(DW), .KEEP_WIDTH(KW),
        .AXI4_RQ_TUSER_WIDTH(RQU), .AXI4_RC_TUSER_WIDTH(RCU)
    ) dut (
        .user_clk(user_clk), .user_reset(user_reset), .user_lnk_up(user_lnk_up),
        .req_tdata(req_tdata), .req_tuser(req_tuser), .req_tkeep(req_tkeep),
        .req_tlast(req_tlast), .req_tvalid(req_tvalid), .req_tready(req_tready),
        .s_axis_rq_tdata(s_axis_rq_tdata), .s_axis_rq_tuser(s_axis_rq_tuser),
        .s_axis_rq_tkeep(s_axis_rq_tkeep), .s_axis_rq_tlast(s_axis_rq_tlast),
        .s_axis_rq_tvalid(s_axis_rq_tvalid), .s_axis_rq_tready(s_axis_rq_tready),
        .m_axis_rc_tdata(m_axis_rc_tdata), .m_axis_rc_tuser(m_axis_rc_tuser),
        .m_axis_rc_tkeep(m_axis_rc_tkeep), .m_axis_rc_tlast(m_axis_rc_tlast),
        .m_axis_rc_tvalid(m_axis_rc_tvalid), .m_axis_rc_tready(m_axis_rc_tready),
        .rc_tdata(rc_tdata), .rc_tuser(rc_tuser), .rc_tkeep(rc_tkeep),
        .rc_tlast(rc_tlast), .rc_tvalid(rc_tvalid), .rc_tready(rc_tready),
        .rq_pkt_cnt(rq_pkt_cnt), .arb_busy(arb_busy)
    );

    always #5 user_clk = ~user_clk;

    task automatic chk(input string tag, input logic ok);
        total++;
        if (ok !== 1'b1) begin
            bad++;
            $display("FAIL %s", tag);
        end else begin
            $display("PASS %s", tag);
        end
    endtask

    function automatic logic [DW-1:0] mk(input logic [7:0] tag, input logic [15:0] id);
        logic [DW-1:0] r;
        r          = '0;
        r[127:112] = 16'hBEEF;
        r[103:96]  = tag;
        r[15:0]    = id;
        return r;
    endfunction

    task automatic tick();
        @(posedge user_clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [DW-1:0] d, input logic last);
        req_tdata[i*DW +: DW] = d;
        req_tlast[i]          = last;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a0, a1, a2, c0, w;
        user_reset       = 1'b1;
        user_lnk_up      = 1'b1;
        req_tdata        = '0;
        req_tuser        = '0;
        req_tkeep        = '0;
        req_tlast        = '0;
        req_tvalid       = '0;
        s_axis_rq_tready = 4'hF;
        m_axis_rc_tdata  = '0;
        m_axis_rc_tuser  = '0;
        m_axis_rc_tkeep  = '0;
        m_axis_rc_tlast  = 1'b0;
        m_axis_rc_tvalid = 1'b0;
        rc_tready        = '0;
        repeat (3) tick();

        chk("rst_tvalid", s_axis_rq_tvalid === 1'b0);
        chk("rst_tdata", s_axis_rq_tdata === 128'h0);
        chk("rst_tready", req_tready === 3'b000);
        chk("rst_busy", arb_busy === 1'b0);
        chk("rst_cnt", rq_pkt_cnt === 48'h0);
        user_reset = 1'b0;

        set_req(1, mk(8'h05, 16'h1000), 1'b0);
        req_tuser[1*RQU +: RQU] = 62'h2A5A_5A5A_5A5A_5A5;
        req_tkeep[1*KW +: KW]   = 4'hF;
        req_tvalid = 3'b010;
        #1;
        chk("t1_arb_noready", req_tready === 3'b000);
        tick();
        chk("t1_busy", arb_busy === 1'b1);
        chk("t1_ready", req_tready === 3'b010);
        chk("t1_bubble", s_axis_rq_tvalid === 1'b0);
        tick();
        chk("t1_b0_valid", s_axis_rq_tvalid === 1'b1);
        chk("t1_b0_tag", s_axis_rq_tdata[103:96] === 8'h45);
        chk("t1_b0_data", s_axis_rq_tdata === mk(8'h45, 16'h1000));
        chk("t1_b0_tuser", s_axis_rq_tuser === 62'h2A5A_5A5A_5A5A_5A5);
        chk("t1_b0_tkeep", s_axis_rq_tkeep === 4'hF);
        chk("t1_b0_tlast", s_axis_rq_tlast === 1'b0);
        set_req(1, mk(8'h05, 16'h1001), 1'b1);
        tick();
        chk("t1_b1_valid", s_axis_rq_tvalid === 1'b1);
        chk("t1_b1_data", s_axis_rq_tdata === mk(8'h05, 16'h1001));
        chk("t1_b1_tlast", s_axis_rq_tlast === 1'b1);
        chk("t1_b1_ready", req_tready === 3'b000);
        chk("t1_b1_busy", arb_busy === 1'b0);
        req_tvalid = 3'b000;
        req_tlast  = 3'b000;
        tick();
        chk("t1_drain", s_axis_rq_tvalid === 1'b0);
        chk("t1_cnt1", rq_pkt_cnt[31:16] === 16'(STAT));

        user_reset = 1'b1;
        tick();
        chk("t2_cnt_clear", rq_pkt_cnt === 48'h0);
        user_reset = 1'b0;
        for (int i = 0; i < N; i++) set_req(i, mk(8'h00, 16'(16'h2000 + i)), 1'b1);
        req_tvalid = 3'b111;
        for (int p = 0; p < 6; p++) begin
            tick();
            chk("t2_grant", req_tready === 3'(1 << (p % 3)));
            chk("t2_gap", s_axis_rq_tvalid === 1'b0);
            tick();
            chk("t2_valid", s_axis_rq_tvalid === 1'b1);
            chk("t2_tag", s_axis_rq_tdata[103:102] === 2'(p % 3));
            chk("t2_id", s_axis_rq_tdata[15:0] === 16'(16'h2000 + (p % 3)));
        end
        req_tvalid = 3'b000;
        tick();
        tick();
        chk("t2_cnt0", rq_pkt_cnt[15:0] === 16'(2 * STAT));
        chk("t2_cnt2", rq_pkt_cnt[47:32] === 16'(2 * STAT));

        a0 = mk(8'h07, 16'h3000);
        a1 = mk(8'h07, 16'h3001);
        a2 = mk(8'h07, 16'h3002);
        c0 = mk(8'h09, 16'h3200);
        set_req(0, a0, 1'b0);
        set_req(2, c0, 1'b1);
        req_tvalid = 3'b101;
        tick();
        chk("t3_grant0", req_tready === 3'b001);
        tick();
        chk("t3_a0", s_axis_rq_tdata === a0);
        set_req(0, a1, 1'b0);
        tick();
        chk("t3_a1", s_axis_rq_tdata === a1);
        s_axis_rq_tready = 4'h0;
        set_req(0, a2, 1'b1);
        for (int s = 0; s < 3; s++) begin
            tick();
            chk("t3_hold_valid", s_axis_rq_tvalid === 1'b1);
            chk("t3_hold_data", s_axis_rq_tdata === a1);
            chk("t3_hold_ready", req_tready === 3'b000);
            chk("t3_hold_busy", arb_busy === 1'b1);
        end
        s_axis_rq_tready = 4'h2;
        #1;
        chk("t3_resume_ready", req_tready === 3'b001);
        tick();
        chk("t3_a2", s_axis_rq_tdata === a2);
        chk("t3_a2_last", s_axis_rq_tlast === 1'b1);
        chk("t3_no_grant2", req_tready === 3'b000);
        req_tvalid = 3'b100;
        tick();
        chk("t3_grant2", req_tready === 3'b100);
        chk("t3_a2_gone", s_axis_rq_tvalid === 1'b0);
        tick();
        chk("t3_c0", s_axis_rq_tdata === mk(8'h89, 16'h3200));
        req_tvalid = 3'b000;
        tick();
        chk("t3_cnt0", rq_pkt_cnt[15:0] === 16'(3 * STAT));
        chk("t3_cnt2", rq_pkt_cnt[47:32] === 16'(3 * STAT));

        w = '0;
        w[71:64] = 8'h83;
        w[7:0]   = 8'h5C;
        m_axis_rc_tdata  = w;
        m_axis_rc_tlast  = 1'b0;
        m_axis_rc_tvalid = 1'b1;
        rc_tready        = 3'b011;
        #1;
        chk("t4_rcv0", rc_tvalid === 3'b100);
        chk("t4_mrdy0", m_axis_rc_tready === 1'b0);
        chk("t4_bcast", rc_tdata === w);
        tick();
        rc_tready = 3'b111;
        #1;
        chk("t4_rcv1", rc_tvalid === 3'b100);
        chk("t4_mrdy1", m_axis_rc_tready === 1'b1);
        tick();
        w = '0;
        w[7:0] = 8'hA7;
        m_axis_rc_tdata = w;
        m_axis_rc_tlast = 1'b1;
        rc_tready       = 3'b011;
        #1;
        chk("t4_latched_v", rc_tvalid === 3'b100);
        chk("t4_latched_r", m_axis_rc_tready === 1'b0);
        rc_tready = 3'b111;
        tick();
        w = '0;
        w[71:64] = 8'h01;
        m_axis_rc_tdata = w;
        #1;
        chk("t4_released", rc_tvalid === 3'b001);
        tick();

        w = '0;
        w[71:64] = 8'hC1;
        m_axis_rc_tdata = w;
        m_axis_rc_tlast = 1'b1;
        rc_tready       = 3'b000;
        #1;
        chk("t5_drop_v", rc_tvalid === 3'b000);
        chk("t5_drop_r", m_axis_rc_tready === 1'b1);
        tick();
        m_axis_rc_tvalid = 1'b0;
        #1;
        chk("t5_idle_v", rc_tvalid === 3'b000);

        set_req(1, mk(8'h03, 16'h4100), 1'b0);
        set_req(0, mk(8'h02, 16'h4000), 1'b1);
        req_tvalid = 3'b010;
        tick();
        chk("t6_grant1", req_tready === 3'b010);
        tick();
        chk("t6_valid", s_axis_rq_tvalid === 1'b1);
        chk("t6_cnt0_pre", rq_pkt_cnt[15:0] === 16'(3 * STAT));
        user_lnk_up = 1'b0;
        tick();
        chk("t6_down_valid", s_axis_rq_tvalid === 1'b0);
        chk("t6_down_ready", req_tready === 3'b000);
        chk("t6_down_cnt", rq_pkt_cnt === 48'h0);
        chk("t6_down_busy", arb_busy === 1'b0);
        user_lnk_up = 1'b1;
        set_req(1, mk(8'h03, 16'h4101), 1'b1);
        req_tvalid = 3'b011;
        tick();
        chk("t6_restart0", req_tready === 3'b001);
        tick();
        chk("t6_out0", s_axis_rq_tdata === mk(8'h02, 16'h4000));
        req_tvalid = 3'b000;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
